// File: rtl/decode_window.sv
// rtl/decode_window.sv - byte-stream aligner presenting a first-byte-aligned window to the decoder
module decode_window #(
    parameter int IN_BYTES     = 4,
    parameter int WINDOW_BYTES = 12,
    parameter int BUF_BYTES    = 16,
    parameter int LEN_W        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_BYTES*8-1:0]         in_data,
    input  logic [$clog2(IN_BYTES):0]     in_count,
    input  logic                          in_last,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [WINDOW_BYTES*8-1:0]     win_data,
    output logic [$clog2(WINDOW_BYTES):0] win_count,
    input  logic [LEN_W-1:0]              consume_len,
    output logic                          err,
    output logic                          drained,
    output logic [31:0]                   instr_count
);

    localparam int OCC_W = $clog2(BUF_BYTES + 1);
    localparam int WC_W  = $clog2(WINDOW_BYTES) + 1;
    localparam int BUF_W = BUF_BYTES * 8;
    localparam int IN_W  = IN_BYTES * 8;
    localparam int WIN_W = WINDOW_BYTES * 8;

    // The buffer must hold a full window plus a partially merged beat; the length
    // field must be able to express a full-window instruction.
    if (BUF_BYTES < WINDOW_BYTES + IN_BYTES - 1) begin : g_bad_buf
        $error("decode_window: BUF_BYTES too small for WINDOW_BYTES + IN_BYTES - 1");
    end
    if ((1 << LEN_W) <= WINDOW_BYTES) begin : g_bad_len
        $error("decode_window: LEN_W too narrow for WINDOW_BYTES");
    end

    // Head byte sits in the MSBs; bytes past occ are kept zero at all times.
    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             drained_q, drained_d;
    logic [31:0]      icount_q, icount_d;

    int occ_i;
    int wc_i;
    int cl_i;
    int cnt_i;

    assign occ_i = int'(occ_q);
    assign wc_i  = (occ_i > WINDOW_BYTES) ? WINDOW_BYTES : occ_i;
    assign cl_i  = int'(consume_len);
    assign cnt_i = int'(in_count);

    // Handshake qualifiers are derived from registered state only.
    always_comb begin
        in_ready  = !last_q && !err_q && (occ_i + IN_BYTES <= BUF_BYTES);
        win_valid = !err_q && (occ_i >= WINDOW_BYTES || (last_q && occ_i > 0));
        win_count = WC_W'(wc_i);
    end

    // Window is the buffer head with bytes beyond win_count forced to zero.
    always_comb begin
        logic [WIN_W-1:0] mask;
        mask     = ~({WIN_W{1'b1}} >> (wc_i * 8));
        win_data = buffer_q[BUF_W-1 -: WIN_W] & mask;
    end

    // Next-state: retire the consumed head first, then merge the new beat behind it.
    always_comb begin
        logic             in_hs, win_hs;
        logic             cons_ok, cons_bad, app_ok, app_bad;
        int               shift_i, base_i, occ_n;
        logic [IN_W-1:0]  beat;
        logic [BUF_W-1:0] placed;

        in_hs    = in_valid && in_ready;
        win_hs   = win_valid && win_ready;
        cons_ok  = win_hs && (cl_i >= 1) && (cl_i <= wc_i);
        cons_bad = win_hs && !cons_ok;
        app_ok   = in_hs && (cnt_i >= 1) && (cnt_i <= IN_BYTES);
        app_bad  = in_hs && !app_ok;

        shift_i = cons_ok ? cl_i : 0;
        base_i  = occ_i - shift_i;
        beat    = in_data & ~({IN_W{1'b1}} >> (cnt_i * 8));
        placed  = {beat, {(BUF_W - IN_W){1'b0}}} >> (base_i * 8);
        occ_n   = base_i + (app_ok ? cnt_i : 0);

        buffer_d  = (buffer_q << (shift_i * 8)) | (app_ok ? placed : '0);
        occ_d     = OCC_W'(occ_n);
        err_d     = err_q | cons_bad | app_bad;
        icount_d  = icount_q + (cons_ok ? 32'd1 : 32'd0);
        last_d    = last_q;
        drained_d = 1'b0;

        if (cons_ok && last_q && base_i == 0) begin
            last_d    = 1'b0;
            drained_d = 1'b1;
        end
        if (app_ok && in_last) begin
            last_d = 1'b1;
        end

        if (flush) begin
            buffer_d  = '0;
            occ_d     = '0;
            err_d     = 1'b0;
            last_d    = 1'b0;
            drained_d = 1'b0;
            icount_d  = icount_q;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer_q  <= '0;
            occ_q     <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            drained_q <= 1'b0;
            icount_q  <= '0;
        end else begin
            buffer_q  <= buffer_d;
            occ_q     <= occ_d;
            last_q    <= last_d;
            err_q     <= err_d;
            drained_q <= drained_d;
            icount_q  <= icount_d;
        end
    end

    assign err         = err_q;
    assign drained     = drained_q;
    assign instr_count = icount_q;

endmodule

// File: tb/tb_decode_window.sv
// tb/tb_decode_window.sv - scoreboard bench for decode_window with queue-based reference model
module tb_decode_window;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  in_count = '0;
    logic        in_last = 1'b0;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [95:0] win_data;
    logic [4:0]  win_count;
    logic [3:0]  consume_len = '0;
    logic        err;
    logic        drained;
    logic [31:0] instr_count;

    decode_window dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_count(in_count), .in_last(in_last),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_count(win_count), .consume_len(consume_len),
        .err(err), .drained(drained), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_ready;
        logic        win_valid;
        int          wcount;
        logic [95:0] wdata;
        logic        err;
        logic        drained;
        logic [31:0] icount;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the buffered stream as a plain byte queue.
    byte unsigned mq[$];
    logic         m_last = 1'b0;
    logic         m_err = 1'b0;
    logic         m_drained = 1'b0;
    logic [31:0]  m_ic = '0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int model_wcount();
        return (mq.size() > 12) ? 12 : mq.size();
    endfunction

    // One clock of stimulus: publish expectation for the current cycle, drive, advance the model.
    task automatic step(input logic iv, input logic [31:0] d, input int cnt, input logic lst,
                        input logic wr, input int cl, input logic fl);
        exp_t e;
        @(negedge clk);
        e.in_ready  = !m_last && !m_err && (mq.size() + 4 <= 16);
        e.win_valid = !m_err && (mq.size() >= 12 || (m_last && mq.size() > 0));
        e.wcount    = model_wcount();
        e.wdata     = '0;
        for (int i = 0; i < e.wcount; i++) e.wdata[95 - 8*i -: 8] = mq[i];
        e.err       = m_err;
        e.drained   = m_drained;
        e.icount    = m_ic;
        exp_q.push_back(e);

        in_valid    = iv;
        in_data     = d;
        in_count    = 3'(cnt);
        in_last     = lst;
        win_ready   = wr;
        consume_len = 4'(cl);
        flush       = fl;

        m_drained = 1'b0;
        if (fl) begin
            mq.delete();
            m_last = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (e.win_valid && wr) begin
                if (cl >= 1 && cl <= e.wcount) begin
                    for (int k = 0; k < cl; k++) void'(mq.pop_front());
                    m_ic++;
                    if (m_last && mq.size() == 0) begin
                        m_drained = 1'b1;
                        m_last    = 1'b0;
                    end
                end else begin
                    m_err = 1'b1;
                end
            end
            if (iv && e.in_ready) begin
                if (cnt >= 1 && cnt <= 4) begin
                    for (int k = 0; k < cnt; k++) mq.push_back(d[31 - 8*k -: 8]);
                    if (lst) m_last = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: pops the expectation for each cycle and compares against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("in_ready", 128'(in_ready), 128'(e.in_ready));
                chk("win_valid", 128'(win_valid), 128'(e.win_valid));
                chk("win_count", 128'(win_count), 128'(e.wcount));
                chk("win_data", 128'(win_data), 128'(e.wdata));
                chk("err", 128'(err), 128'(e.err));
                chk("drained", 128'(drained), 128'(e.drained));
                chk("instr_count", 128'(instr_count), 128'(e.icount));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cl, cnt;
        logic iv, lst, wr, fl;

        // Reset state
        #2;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_win_valid", 128'(win_valid), 128'(0));
        chk("rst_win_data", 128'(win_data), 128'(0));
        chk("rst_instr_count", 128'(instr_count), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 0x90 x12, consume one byte per cycle until the stream drains
        step(1, 32'h90909090, 4, 0, 1, 1, 0);
        step(1, 32'h90909090, 4, 0, 1, 1, 0);
        step(1, 32'h90909090, 4, 1, 1, 1, 0);
        step(0, 32'h0, 0, 0, 0, 1, 0);
        #1;
        chk("t1_head", 128'(win_data[95:88]), 128'(8'h90));
        repeat (12) step(0, 32'h0, 0, 0, 1, 1, 0);
        repeat (2) idle();
        #1;
        chk("t1_instr_count", 128'(instr_count), 128'(12));

        // Partial stream with a trailing single byte
        step(1, 32'h66B83412, 4, 0, 0, 0, 0);
        step(1, 32'h00009090, 4, 0, 0, 0, 0);
        step(1, 32'hC3000000, 1, 1, 0, 0, 0);
        idle();
        #1;
        chk("t2_win_count", 128'(win_count), 128'(9));
        chk("t2_win_data", 128'(win_data), 128'(96'h66B8341200009090C3000000));
        step(0, 32'h0, 0, 0, 1, 6, 0);
        idle();
        #1;
        chk("t2_win_count_after6", 128'(win_count), 128'(3));
        chk("t2_head_after6", 128'(win_data[95:88]), 128'(8'h90));
        repeat (3) step(0, 32'h0, 0, 0, 1, 1, 0);
        repeat (2) idle();

        // Continuous beats with consume_len=4 every cycle
        repeat (24) step(1, $urandom, 4, 0, 1, 4, 0);
        #1;
        chk("t3_in_ready", 128'(in_ready), 128'(1));
        chk("t3_win_valid", 128'(win_valid), 128'(1));
        chk("t3_win_count", 128'(win_count), 128'(12));

        // Illegal consume lengths at occ=12, then flush
        step(0, 32'h0, 0, 0, 1, 13, 0);
        step(0, 32'h0, 0, 0, 1, 0, 0);
        idle();
        #1;
        chk("t4_err", 128'(err), 128'(1));
        step(0, 32'h0, 0, 0, 0, 0, 1);
        idle();

        // Flush beats a simultaneous in and win handshake; also flush from full
        repeat (3) step(1, $urandom, 4, 0, 0, 0, 0);
        step(1, $urandom, 4, 0, 1, 2, 1);
        idle();
        repeat (4) step(1, $urandom, 4, 0, 0, 0, 0);
        step(1, $urandom, 4, 0, 1, 2, 1);
        idle();

        // Illegal in_count on an accepted beat
        step(1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle();
        step(0, 32'h0, 0, 0, 0, 0, 1);
        idle();

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            iv  = ($urandom_range(0, 3) != 0);
            cnt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 4;
            lst = ($urandom_range(0, 15) == 0);
            wr  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) cl = $urandom_range(0, 15);
            else cl = $urandom_range(1, (model_wcount() > 0) ? model_wcount() : 1);
            fl  = ($urandom_range(0, 49) == 0) || (m_err && $urandom_range(0, 3) == 0);
            step(iv, $urandom, cnt, lst, wr, cl, fl);
        end

        // Asynchronous reset mid-stream at occ=7
        step(0, 32'h0, 0, 0, 0, 0, 1);
        step(1, 32'h11223344, 4, 0, 0, 0, 0);
        step(1, 32'h55667700, 3, 0, 0, 0, 0);
        idle();
        #1;
        chk("t6_pre_count", 128'(win_count), 128'(7));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_win_valid", 128'(win_valid), 128'(0));
        chk("t6_in_ready", 128'(in_ready), 128'(1));
        chk("t6_instr_count", 128'(instr_count), 128'(0));
        chk("t6_win_data", 128'(win_data), 128'(0));
        mq.delete();
        m_last    = 1'b0;
        m_err     = 1'b0;
        m_drained = 1'b0;
        m_ic      = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle();
        step(1, 32'hA1A2A3A4, 4, 1, 1, 1, 0);
        repeat (6) step(0, 32'h0, 0, 0, 1, 1, 0);

        repeat (2) @(negedge clk);
        #2;
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
